// File: rtl/rr_arbiter_bin.sv
// -----------------------------------------------------------------------------
// rr_arbiter_bin
//
// Round-robin arbiter over N_REQ requesters. The winner is presented as a
// registered binary index (grant_bin_o) with a valid/ready handshake. It feeds a
// binary-to-one-hot decoder downstream. Priority rotates: after a grant is
// accepted, the index just above the served requester becomes highest priority.
//
// Ports
//   clk_i          : clock, all state changes on the rising edge
//   rst_ni         : asynchronous active-low reset
//   req_i          : request vector, bit k = requester k wants a grant
//   grant_ready_i  : consumer accepts the offered grant this cycle
//   grant_valid_o  : grant_bin_o holds a valid offer (high exactly in OFFER)
//   grant_bin_o    : binary index of the granted requester
//
// Parameters
//   N_REQ : number of requesters, must equal 1 << BIN_W
//   BIN_W : width of the binary grant index
// -----------------------------------------------------------------------------
module rr_arbiter_bin #(
    parameter int N_REQ = 16,
    parameter int BIN_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_REQ-1:0] req_i,
    input  logic             grant_ready_i,
    output logic             grant_valid_o,
    output logic [BIN_W-1:0] grant_bin_o
);

    // All index arithmetic relies on natural BIN_W-bit wrap. That wrap only
    // equals "modulo N_REQ" when N_REQ is exactly a power of two matching BIN_W.
    // If the parameters disagree, elaboration stops here.
    if (N_REQ != (1 << BIN_W)) begin : g_bad_params
        $error("rr_arbiter_bin: N_REQ=%0d does not equal 1<<BIN_W (BIN_W=%0d)",
               N_REQ, BIN_W);
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   grant_q, grant_d;
    logic [BIN_W-1:0]   ptr_q,   ptr_d;

    // One-hot of the currently offered index. It is used to exclude the
    // requester just served from the back-to-back search in the handshake
    // cycle.
    logic [N_REQ-1:0]   served_oh;
    logic [N_REQ-1:0]   req_masked;
    logic [BIN_W-1:0]   next_base;
    logic               handshake;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_served
        assign served_oh[gi] = (grant_q == BIN_W'(gi));
    end

    assign req_masked = req_i & ~served_oh;
    assign next_base  = grant_q + BIN_W'(1);
    assign handshake  = (state_q == ST_OFFER) && grant_ready_i;

    // The first set bit of vec, searching base, base+1, ... with BIN_W-bit
    // wrap. Callers only use the result when vec is non-zero.
    function automatic logic [BIN_W-1:0] winner(
        input logic [BIN_W-1:0] base,
        input logic [N_REQ-1:0] vec
    );
        logic [BIN_W-1:0] idx;
        logic             found;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = base + BIN_W'(i);
            if (!found && vec[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    endfunction

    // Next-state logic. An offer is frozen until it is accepted. Request
    // changes during OFFER (including withdrawal) never alter it.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    grant_d = winner(ptr_q, req_i);
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (handshake) begin
                    ptr_d = next_base;
                    if (|req_masked) begin
                        // Back-to-back grant. next_base equals the new ptr.
                        grant_d = winner(next_base, req_masked);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Outputs come straight from flops.
    assign grant_valid_o = (state_q == ST_OFFER);
    assign grant_bin_o   = grant_q;

endmodule

// File: tb/tb_rr_arbiter_bin.sv
module tb_rr_arbiter_bin;

    localparam int N_REQ = 16;
    localparam int BIN_W = 4;

    logic             clk_i;
    logic             rst_ni;
    logic [N_REQ-1:0] req_i;
    logic             grant_ready_i;
    logic             grant_valid_o;
    logic [BIN_W-1:0] grant_bin_o;

    rr_arbiter_bin #(.N_REQ(N_REQ), .BIN_W(BIN_W)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .grant_ready_i (grant_ready_i),
        .grant_valid_o (grant_valid_o),
        .grant_bin_o   (grant_bin_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        string            name;
        logic             valid;
        logic [BIN_W-1:0] bin;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: at each falling edge, pop the expectation for this cycle and
    // compare it against the DUT outputs.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (grant_valid_o !== e.valid || (e.valid && grant_bin_o !== e.bin)
                || (!e.valid && grant_bin_o !== e.bin)) begin
                bad++;
                $display("FAIL %s: got valid=%0b bin=%0d, required valid=%0b bin=%0d",
                         e.name, grant_valid_o, grant_bin_o, e.valid, e.bin);
            end else begin
                $display("ok   %s: valid=%0b bin=%0d", e.name, grant_valid_o, grant_bin_o);
            end
        end
    end

    // Drive inputs for this cycle and queue the outputs expected in this cycle.
    task automatic step(input string name, input logic [N_REQ-1:0] req,
                        input logic rdy, input logic ev, input int eb);
        exp_t e;
        @(posedge clk_i);
        #1;
        req_i         = req;
        grant_ready_i = rdy;
        e.name  = name;
        e.valid = ev;
        e.bin   = BIN_W'(eb);
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        rst_ni        = 1'b0;
        req_i         = '0;
        grant_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #1 rst_ni = 1'b1;

        step("reset_state", 16'h0000, 1'b0, 1'b0, 0);

        // Full fairness from reset: 0..15 then 0,1 with no bubbles.
        step("fair_req", 16'hFFFF, 1'b1, 1'b0, 0);
        for (int i = 0; i < 18; i++)
            step($sformatf("fair_%0d", i), 16'hFFFF, 1'b1, 1'b1, i % 16);
        step("fair_last", 16'h0000, 1'b1, 1'b1, 2);
        step("fair_idle", 16'h0000, 1'b0, 1'b0, 2);

        // Single persistent requester 4: granted every other cycle.
        step("single_req", 16'h0010, 1'b1, 1'b0, 2);
        step("single_g0",  16'h0010, 1'b1, 1'b1, 4);
        step("single_b0",  16'h0010, 1'b1, 1'b0, 4);
        step("single_g1",  16'h0010, 1'b1, 1'b1, 4);
        step("single_b1",  16'h0010, 1'b1, 1'b0, 4);
        step("single_g2",  16'h0010, 1'b1, 1'b1, 4);
        step("single_end", 16'h0000, 1'b1, 1'b0, 4);
        step("single_idle",16'h0000, 1'b0, 1'b0, 4);

        // Backpressure: offer of 0 held, request change ignored.
        step("bp_req",  16'h0005, 1'b0, 1'b0, 4);
        step("bp_c1",   16'h0005, 1'b0, 1'b1, 0);
        step("bp_c2",   16'h0005, 1'b0, 1'b1, 0);
        step("bp_c3",   16'h0004, 1'b0, 1'b1, 0);
        step("bp_c4",   16'h0004, 1'b0, 1'b1, 0);
        step("bp_rdy",  16'h0004, 1'b1, 1'b1, 0);
        step("bp_g2",   16'h0004, 1'b1, 1'b1, 2);
        step("bp_idle", 16'h0000, 1'b0, 1'b0, 2);

        // Reset during a pending offer of index 0.
        step("rst_req",     16'h0003, 1'b0, 1'b0, 2);
        step("rst_offer",   16'h0003, 1'b0, 1'b1, 0);
        @(posedge clk_i);
        #1;
        rst_ni        = 1'b0;
        grant_ready_i = 1'b1;
        e.name = "rst_async"; e.valid = 1'b0; e.bin = '0;
        exp_q.push_back(e);
        @(negedge clk_i);
        #1 rst_ni = 1'b1;
        step("rst_after_g0", 16'h0003, 1'b1, 1'b1, 0);
        step("rst_after_g1", 16'h0000, 1'b1, 1'b1, 1);
        step("rst_idle",     16'h0000, 1'b0, 1'b0, 1);

        // Wrap-around: serve 14, then 15 and 0 back-to-back.
        step("wrap_req14", 16'h4000, 1'b1, 1'b0, 1);
        step("wrap_g14",   16'h4000, 1'b1, 1'b1, 14);
        step("wrap_req",   16'h8001, 1'b1, 1'b0, 14);
        step("wrap_g15",   16'h8001, 1'b1, 1'b1, 15);
        step("wrap_g0",    16'h8001, 1'b1, 1'b1, 0);
        step("wrap_g15b",  16'h0000, 1'b1, 1'b1, 15);
        step("wrap_idle",  16'h0000, 1'b0, 1'b0, 15);

        // Let the monitor drain; a leftover entry means it never ran.
        @(negedge clk_i);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
